// File: rtl/mig_topk_merger_if.sv
// Migration address stream toward the CDC FIFO.
// master drives valid/data, slave answers with ready.
interface mig_topk_merger_if #(
  parameter int ADDR_SIZE = 28
);
  logic                 valid;
  logic [ADDR_SIZE-1:0] data;
  logic                 ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/mig_topk_merger.sv
// Merges NUM_CH sorted per-channel hot-page lists into a global top-K
// stream. Ports: clk/rst, ch_* lists in, mig stream out, round status out.
module mig_topk_merger #(
  parameter int ADDR_SIZE = 28,
  parameter int CNT_SIZE  = 13,
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 5,
  parameter int TOP_K     = 5,
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CH-1:0]                   ch_mig_en_i,
  input  logic [NUM_CH*DEPTH*ADDR_SIZE-1:0]   ch_addr_i,
  input  logic [NUM_CH*DEPTH*CNT_SIZE-1:0]    ch_cnt_i,
  input  logic [CNT_SIZE-1:0]                 min_cnt_i,
  mig_topk_merger_if.master                   mig,
  output logic [NUM_CH*NW-1:0]                ch_num_mig_o,
  output logic                                done_o,
  output logic                                busy_o,
  output logic [7:0]                          drop_cnt_o
);
  localparam int EW = $clog2(TOP_K + 1);

  typedef enum logic [1:0] {
    COLLECT,
    MERGE,
    FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_SIZE-1:0] addr_q [NUM_CH][DEPTH];
  logic [ADDR_SIZE-1:0] addr_d [NUM_CH][DEPTH];
  logic [CNT_SIZE-1:0]  cnt_q  [NUM_CH][DEPTH];
  logic [CNT_SIZE-1:0]  cnt_d  [NUM_CH][DEPTH];

  logic [NUM_CH-1:0]    arrived_q, arrived_d;
  // head also serves as the per-channel taken count
  logic [NW-1:0]        head_q [NUM_CH];
  logic [NW-1:0]        head_d [NUM_CH];
  logic [NW-1:0]        num_q  [NUM_CH];
  logic [NW-1:0]        num_d  [NUM_CH];
  logic [EW-1:0]        emit_q, emit_d;
  logic [CNT_SIZE-1:0]  min_q, min_d;
  logic                 valid_q, valid_d;
  logic [ADDR_SIZE-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic [7:0]           drop_q, drop_d;

  logic                 hd_ok   [NUM_CH];
  logic [CNT_SIZE-1:0]  hd_cnt  [NUM_CH];
  logic [ADDR_SIZE-1:0] hd_addr [NUM_CH];

  logic                 win_ok;
  logic [NUM_CH-1:0]    win_oh;
  logic [CNT_SIZE-1:0]  win_cnt;
  logic [ADDR_SIZE-1:0] win_addr;
  logic                 slot;

  assign slot = !valid_q || mig.ready;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      hd_ok[c]   = head_q[c] < NW'(DEPTH);
      hd_cnt[c]  = '0;
      hd_addr[c] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (head_q[c] == NW'(j)) begin
          hd_cnt[c]  = cnt_q[c][j];
          hd_addr[c] = addr_q[c][j];
        end
      end
    end
  end

  // strict > keeps the lowest channel on equal counts
  always_comb begin
    win_ok   = 1'b0;
    win_oh   = '0;
    win_cnt  = '0;
    win_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hd_ok[c] && (!win_ok || hd_cnt[c] > win_cnt)) begin
        win_ok    = 1'b1;
        win_oh    = '0;
        win_oh[c] = 1'b1;
        win_cnt   = hd_cnt[c];
        win_addr  = hd_addr[c];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    arrived_d = arrived_q;
    head_d    = head_q;
    num_d     = num_q;
    emit_d    = emit_q;
    min_d     = min_q;
    valid_d   = valid_q;
    data_d    = data_q;
    done_d    = 1'b0;
    drop_d    = drop_q;
    unique case (state_q)
      COLLECT: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_mig_en_i[c]) begin
            arrived_d[c] = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
              addr_d[c][j] =
                ch_addr_i[(c*DEPTH+j)*ADDR_SIZE +: ADDR_SIZE];
              cnt_d[c][j] =
                ch_cnt_i[(c*DEPTH+j)*CNT_SIZE +: CNT_SIZE];
            end
          end
        end
        if (&(arrived_q | ch_mig_en_i)) begin
          state_d = MERGE;
          min_d   = min_cnt_i;
        end
      end
      MERGE: begin
        if (slot) begin
          if (emit_q < EW'(TOP_K) && win_ok &&
              win_cnt >= min_q) begin
            valid_d = 1'b1;
            data_d  = win_addr;
            emit_d  = emit_q + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
              if (win_oh[c]) head_d[c] = head_q[c] + 1'b1;
            end
          end else begin
            state_d = FLUSH;
            valid_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (slot) begin
          valid_d   = 1'b0;
          num_d     = head_q;
          done_d    = 1'b1;
          arrived_d = '0;
          head_d    = '{default: '0};
          emit_d    = '0;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (state_q != COLLECT && |ch_mig_en_i && drop_q != 8'hFF) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      arrived_q <= '0;
      head_q    <= '{default: '0};
      num_q     <= '{default: '0};
      emit_q    <= '0;
      min_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '1;
      done_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      head_q    <= head_d;
      num_q     <= num_d;
      emit_q    <= emit_d;
      min_q     <= min_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  // list storage needs no reset: only read after a fresh latch
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    cnt_q  <= cnt_d;
  end

  always_comb begin
    ch_num_mig_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_num_mig_o[c*NW +: NW] = num_q[c];
    end
  end

  assign mig.valid  = valid_q;
  assign mig.data   = data_q;
  assign done_o     = done_q;
  assign busy_o     = state_q != COLLECT;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_mig_topk_merger.sv
// Directed + randomized bench for mig_topk_merger, two configurations.
// Reference: global stable sort of all entries, thresholded prefix.
module tb_mig_topk_merger;
  localparam int A = 28;
  localparam int C = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // config 0: 2 ch x 5, top 5
  logic             rst0;
  logic [1:0]       en0;
  logic [2*5*A-1:0] a0;
  logic [2*5*C-1:0] c0;
  logic [C-1:0]     min0;
  logic [5:0]       nm0;
  logic             done0, busy0;
  logic [7:0]       drop0;
  mig_topk_merger_if #(.ADDR_SIZE(A)) if0 ();

  mig_topk_merger #(
    .ADDR_SIZE(A), .CNT_SIZE(C), .NUM_CH(2), .DEPTH(5), .TOP_K(5)
  ) u0 (
    .clk(clk), .rst(rst0), .ch_mig_en_i(en0), .ch_addr_i(a0),
    .ch_cnt_i(c0), .min_cnt_i(min0), .mig(if0),
    .ch_num_mig_o(nm0), .done_o(done0), .busy_o(busy0),
    .drop_cnt_o(drop0)
  );

  // config 1: 4 ch x 3, top 12
  logic              rst1;
  logic [3:0]        en1;
  logic [4*3*A-1:0]  a1;
  logic [4*3*C-1:0]  c1;
  logic [C-1:0]      min1;
  logic [7:0]        nm1;
  logic              done1, busy1;
  logic [7:0]        drop1;
  mig_topk_merger_if #(.ADDR_SIZE(A)) if1 ();

  mig_topk_merger #(
    .ADDR_SIZE(A), .CNT_SIZE(C), .NUM_CH(4), .DEPTH(3), .TOP_K(12)
  ) u1 (
    .clk(clk), .rst(rst1), .ch_mig_en_i(en1), .ch_addr_i(a1),
    .ch_cnt_i(c1), .min_cnt_i(min1), .mig(if1),
    .ch_num_mig_o(nm1), .done_o(done1), .busy_o(busy1),
    .drop_cnt_o(drop1)
  );

  logic [A-1:0] la [8][8];
  logic [C-1:0] lc [8][8];
  logic [A-1:0] mq [$];
  int           mtake [8];
  logic [A-1:0] exp0_q [$];
  logic [A-1:0] exp1_q [$];
  int rm0, rm1;
  int exp_drop0 = 0;
  int case0 [5] = '{90, 70, 50, 30, 10};
  int case1 [5] = '{80, 60, 40, 20, 5};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (rm0)
      0: if0.ready = 1'b1;
      1: if0.ready = !if0.ready;
      default: if0.ready = 1'($urandom_range(0, 1));
    endcase
    case (rm1)
      0: if1.ready = 1'b1;
      1: if1.ready = !if1.ready;
      default: if1.ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // repeatedly take the hottest unused entry; ties -> lowest (ch, j)
  task automatic build_model(input int nch, input int dep,
                             input int topk, input logic [C-1:0] thr);
    bit used [8][8];
    for (int c = 0; c < 8; c++) begin
      mtake[c] = 0;
      for (int j = 0; j < 8; j++) used[c][j] = 1'b0;
    end
    mq.delete();
    for (int k = 0; k < topk; k++) begin
      int bc;
      int bj;
      bc = -1;
      bj = 0;
      for (int c = 0; c < nch; c++)
        for (int j = 0; j < dep; j++)
          if (!used[c][j] && (bc < 0 || lc[c][j] > lc[bc][bj])) begin
            bc = c;
            bj = j;
          end
      if (bc < 0) break;
      if (lc[bc][bj] < thr) break;
      used[bc][bj] = 1'b1;
      mq.push_back(la[bc][bj]);
      mtake[bc]++;
    end
  endtask

  task automatic gen_ch(input int c, input int dep);
    int v;
    if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 8191));
    else v = int'($urandom_range(0, 12));
    for (int j = 0; j < dep; j++) begin
      la[c][j] = A'($urandom);
      lc[c][j] = C'(v);
      if (v > 0) v = v - int'($urandom_range(0, v / 2));
    end
  endtask

  task automatic load0();
    for (int c = 0; c < 2; c++)
      for (int j = 0; j < 5; j++) begin
        a0[(c*5+j)*A +: A] = la[c][j];
        c0[(c*5+j)*C +: C] = lc[c][j];
      end
  endtask

  task automatic load1();
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 3; j++) begin
        a1[(c*3+j)*A +: A] = la[c][j];
        c1[(c*3+j)*C +: C] = lc[c][j];
      end
  endtask

  task automatic set_case();
    for (int j = 0; j < 5; j++) begin
      la[0][j] = A'(32'h100 + j);
      lc[0][j] = C'(case0[j]);
      la[1][j] = A'(32'h200 + j);
      lc[1][j] = C'(case1[j]);
    end
  endtask

  // monitors: check each accepted beat and hold-while-stalled
  logic pv0 = 0, pr0 = 0, pdn0 = 0;
  logic [A-1:0] pd0 = '0;
  int beats0 = 0, ndone0 = 0;
  always @(negedge clk) begin
    if (rst0) begin
      pv0  <= 1'b0;
      pdn0 <= 1'b0;
    end else begin
      if (pv0 && !pr0) begin
        chk("hold_valid0", if0.valid, 1);
        chk("hold_data0", if0.data, pd0);
      end
      if (if0.valid && if0.ready) begin
        checks++;
        assert (exp0_q.size() > 0) else begin
          errors++;
          $error("FAIL extra_beat0: observed %0h expected none",
                 if0.data);
        end
        if (exp0_q.size() > 0) chk("beat0", if0.data, exp0_q.pop_front());
        beats0 <= beats0 + 1;
      end
      if (done0) begin
        chk("done_pulse0", pdn0, 0);
        ndone0 <= ndone0 + 1;
      end
      pv0  <= if0.valid;
      pr0  <= if0.ready;
      pd0  <= if0.data;
      pdn0 <= done0;
    end
  end

  logic pv1 = 0, pr1 = 0;
  logic [A-1:0] pd1 = '0;
  int beats1 = 0, ndone1 = 0;
  always @(negedge clk) begin
    if (rst1) begin
      pv1 <= 1'b0;
    end else begin
      if (pv1 && !pr1) chk("hold_data1", if1.data, pd1);
      if (if1.valid && if1.ready) begin
        checks++;
        assert (exp1_q.size() > 0) else begin
          errors++;
          $error("FAIL extra_beat1: observed %0h expected none",
                 if1.data);
        end
        if (exp1_q.size() > 0) chk("beat1", if1.data, exp1_q.pop_front());
        beats1 <= beats1 + 1;
      end
      if (done1) ndone1 <= ndone1 + 1;
      pv1 <= if1.valid;
      pr1 <= if1.ready;
      pd1 <= if1.data;
    end
  end

  task automatic round0(input logic [C-1:0] thr, input int rm,
                        input logic [1:0] last, input bit dp);
    int b, n, k;
    logic [63:0] e;
    load0();
    min0 = thr;
    build_model(2, 5, 5, thr);
    exp0_q = mq;
    e = '0;
    for (int c = 0; c < 2; c++) e[c*3 +: 3] = 3'(mtake[c]);
    rm0 = rm;
    b = beats0;
    n = ndone0;
    en0 = last;
    tick();
    en0 = '0;
    @(negedge clk);
    chk("lat1_valid0", if0.valid, 0);
    chk("lat1_busy0", busy0, 1);
    @(negedge clk);
    chk("lat2_valid0", if0.valid, mq.size() > 0);
    if (dp) begin
      tick();
      en0 = 2'b01;
      a0 = ~a0;
      exp_drop0++;
      tick();
      en0 = '0;
    end
    k = 0;
    while (ndone0 == n && k < 200) begin
      tick();
      k++;
    end
    chk("done_seen0", ndone0 - n, 1);
    chk("beats0", beats0 - b, mq.size());
    chk("leftover0", exp0_q.size(), 0);
    chk("num_mig0", nm0, e);
    chk("drop0", drop0, exp_drop0);
    rm0 = 0;
  endtask

  task automatic round1(input logic [C-1:0] thr, input int rm,
                        input int rst_at);
    int b, n, k;
    logic [63:0] e;
    load1();
    min1 = thr;
    build_model(4, 3, 12, thr);
    exp1_q = mq;
    e = '0;
    for (int c = 0; c < 4; c++) e[c*2 +: 2] = 2'(mtake[c]);
    rm1 = rm;
    b = beats1;
    n = ndone1;
    en1 = 4'hF;
    tick();
    en1 = '0;
    k = 0;
    if (rst_at > 0) begin
      while (beats1 - b < rst_at && k < 200) begin
        tick();
        k++;
      end
      chk("rst_reach1", beats1 - b, rst_at);
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      @(negedge clk);
      chk("rst_valid1", if1.valid, 0);
      chk("rst_busy1", busy1, 0);
      repeat (10) tick();
      chk("rst_nodone1", ndone1, n);
      exp1_q.delete();
    end else begin
      while (ndone1 == n && k < 300) begin
        tick();
        k++;
      end
      chk("done_seen1", ndone1 - n, 1);
      chk("beats1", beats1 - b, mq.size());
      chk("leftover1", exp1_q.size(), 0);
      chk("num_mig1", nm1, e);
    end
    rm1 = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    en0 = '0; en1 = '0;
    a0 = '0; c0 = '0; a1 = '0; c1 = '0;
    min0 = '0; min1 = '0;
    if0.ready = 1'b1; if1.ready = 1'b1;
    rm0 = 0; rm1 = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid0", if0.valid, 0);
    chk("rst_data0", if0.data, {A{1'b1}});
    chk("rst_done0", done0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_drop0", drop0, 0);
    chk("rst_num0", nm0, 0);
    chk("rst_valid1", if1.valid, 0);
    chk("rst_num1", nm1, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    set_case();
    round0(0, 0, 2'b11, 0);
    chk("case1_num0", nm0, 6'b010_011);

    for (int j = 0; j < 5; j++) begin
      la[0][j] = A'($urandom);
      la[1][j] = A'($urandom);
      lc[0][j] = C'(50 - 10 * j);
      lc[1][j] = C'(50 - 5 * j);
    end
    round0(0, 0, 2'b11, 0);

    gen_ch(0, 5);
    for (int j = 0; j < 5; j++) begin
      la[1][j] = A'(32'hBAD0 + j);
      lc[1][j] = C'(8191);
    end
    load0();
    en0 = 2'b10;
    tick();
    en0 = '0;
    tick();
    @(negedge clk);
    chk("stag_idle_a", {busy0, if0.valid}, 0);
    gen_ch(1, 5);
    load0();
    en0 = 2'b10;
    tick();
    en0 = '0;
    tick();
    @(negedge clk);
    chk("stag_idle_b", {busy0, if0.valid}, 0);
    round0(0, 0, 2'b01, 0);

    set_case();
    round0(60, 0, 2'b11, 0);
    chk("thr60_num0", nm0, 6'b010_010);
    round0(100, 0, 2'b11, 0);
    chk("thr100_num0", nm0, 0);

    set_case();
    round0(0, 1, 2'b11, 1);
    gen_ch(0, 5);
    gen_ch(1, 5);
    round0(0, 1, 2'b11, 0);

    repeat (6) begin
      gen_ch(0, 5);
      gen_ch(1, 5);
      round0(C'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
             2'b11, 0);
    end

    for (int c = 0; c < 4; c++) gen_ch(c, 3);
    for (int j = 0; j < 3; j++) lc[2][j] = C'(8000 - j);
    round1(0, 2, 0);
    for (int c = 0; c < 4; c++) gen_ch(c, 3);
    round1(0, 0, 4);
    for (int c = 0; c < 4; c++) gen_ch(c, 3);
    round1(C'($urandom_range(0, 12)), 2, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
